matrix_alu_2x2_seq: RTL

- Sequential, parametrised 2x2 matrix ALU that replaces the separate combinational add, subtract, multiply, transpose and determinant blocks with one shared-datapath unit.
- Operands are accepted through a valid/ready handshake and latched.
- The result is computed over a per-opcode number of cycles; multiply and determinant share a single multiplier.
- The result is presented on a valid/ready output port with backpressure.
- Sits between the operand source and the result consumer in the matrix datapath.

---
 rtl/matrix_alu_2x2_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/matrix_alu_2x2_seq.sv
// Sequential 2x2 matrix ALU (add/sub/mul/transpose/det) with one shared multiplier and valid/ready handshakes.
// Define MATRIX_ALU_PERF_EN to add the op_count output-handshake counter.
module matrix_alu_2x2_seq #(
  parameter int DATA_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [4*DATA_W-1:0]         a_in,
  input  logic [4*DATA_W-1:0]         b_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*(2*DATA_W+2)-1:0]   res_out,
  output logic                        err
`ifdef MATRIX_ALU_PERF_EN
  ,
  output logic [15:0]                 op_count
`endif
);
  localparam int RES_W = 2*DATA_W+2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_TRN = 3'd3;
  localparam logic [2:0] OP_DET = 3'd4;

  logic [1:0]          r_state;
  logic [2:0]          r_op;
  logic [2:0]          r_step;
  logic [4*DATA_W-1:0] r_a;
  logic [4*DATA_W-1:0] r_b;
  logic [RES_W-1:0]    r_acc;
  logic [4*RES_W-1:0]  r_res;
  logic                r_err;

  logic                w_accept;
  logic                w_valid_op;
  logic [2:0]          w_last;
  logic [DATA_W-1:0]   w_ma;
  logic [DATA_W-1:0]   w_mb;
  logic [RES_W-1:0]    w_prod;
  logic [4*RES_W-1:0]  w_simple;

  // Element e of a packed matrix; e=0 is x11 (MSBs), e=3 is x22.
  function automatic logic [DATA_W-1:0] elem(input logic [4*DATA_W-1:0] m, input logic [1:0] e);
    return m[(3 - int'(e))*DATA_W +: DATA_W];
  endfunction

  assign in_ready   = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign res_out    = r_res;
  assign err        = r_err;
  assign w_valid_op = (r_op <= OP_DET);

  always_comb begin
    case (r_op)
      OP_MUL:  w_last = 3'd7;
      OP_DET:  w_last = 3'd1;
      default: w_last = 3'd0;
    endcase
  end

  // mul step s = {i, j, k}: product a[i][k] * b[k][j]; det uses a11*a22 then a12*a21.
  always_comb begin
    if (r_op == OP_DET) begin
      w_ma = elem(r_a, r_step[0] ? 2'd1 : 2'd0);
      w_mb = elem(r_a, r_step[0] ? 2'd2 : 2'd3);
    end else begin
      w_ma = elem(r_a, {r_step[2], r_step[0]});
      w_mb = elem(r_b, {r_step[0], r_step[1]});
    end
  end

  assign w_prod = RES_W'(w_ma) * RES_W'(w_mb);

  always_comb begin
    w_simple = '0;
    for (int unsigned e = 0; e < 4; e++) begin
      case (r_op)
        OP_ADD: w_simple[(3-e)*RES_W +: RES_W] = RES_W'(elem(r_a, 2'(e))) + RES_W'(elem(r_b, 2'(e)));
        OP_SUB: w_simple[(3-e)*RES_W +: RES_W] = RES_W'(elem(r_a, 2'(e))) - RES_W'(elem(r_b, 2'(e)));
        OP_TRN: w_simple[(3-e)*RES_W +: RES_W] = RES_W'(elem(r_a, {e[0], e[1]}));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_step  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_a     <= a_in;
            r_b     <= b_in;
            r_step  <= '0;
            r_acc   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          case (r_op)
            OP_MUL: begin
              if (!r_step[0]) r_acc <= w_prod;
              else r_res[(3 - int'(r_step[2:1]))*RES_W +: RES_W] <= r_acc + w_prod;
            end
            OP_DET: begin
              if (!r_step[0]) r_acc <= w_prod;
              else r_res <= {r_acc - w_prod, {(3*RES_W){1'b0}}};
            end
            default: r_res <= w_simple;
          endcase
          r_err <= !w_valid_op;
          if (r_step == w_last) begin
            r_step  <= '0;
            r_state <= S_DONE;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        S_DONE: begin
          if (w_accept) begin
            r_op    <= op;
            r_a     <= a_in;
            r_b     <= b_in;
            r_step  <= '0;
            r_acc   <= '0;
            r_state <= S_CALC;
          end else if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MATRIX_ALU_PERF_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_op_count <= '0;
    else if (out_valid && out_ready) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule
